// File: rtl/pwm_pkg.sv
// Shared types, default widths and duty-bus helper for the multi-channel PWM.
package pwm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int CH_NUM_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int PSC_W_DEF  = 8;

  // LSB position of channel ch inside a packed bus of width-w lanes.
  function automatic int lane_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: duty shadow register, active register and registered compare.
module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_apply,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic             r_pwm;

  // A load coinciding with an apply point bypasses the shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load)
        r_shadow <= i_duty;
      if (i_apply)
        r_active <= i_load ? i_duty : r_shadow;
      if (i_clr)
        r_pwm <= 1'b0;
      else if (i_en)
        r_pwm <= (i_cnt < r_active);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shared prescaler/counter and boundary-synchronous updates.
// Optional centre-aligned counting is enabled by defining PWM_CENTER_ALIGN_EN.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PSC_W  = PSC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    rst_counter,
  input  logic [PSC_W-1:0]        prescale,
  input  logic [CNT_W-1:0]        period,
  input  logic [CH_NUM*CNT_W-1:0] duty,
  input  logic                    duty_load,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                    center_mode,
`endif
  output logic [CH_NUM-1:0]       pwm,
  output logic                    period_done
);

  logic [PSC_W-1:0] r_psc_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_shd;
  logic [CNT_W-1:0] r_period_act;
  logic             r_pend;
  logic             r_period_done;

  logic             w_tick;
  logic             w_boundary;
  logic             w_update;
  logic             w_apply;
  logic [CNT_W-1:0] w_cnt_next;

`ifdef PWM_CENTER_ALIGN_EN
  dir_t r_dir;
  dir_t w_dir_next;
  logic r_center;
`endif

  // Counter next-state; in centre mode the ends are held for one tick on turnaround.
  always_comb begin
    w_tick     = en && (r_psc_cnt == prescale);
    w_cnt_next = r_cnt;
    w_boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    w_dir_next = r_dir;
    if (w_tick) begin
      if (r_center) begin
        case (r_dir)
          DIR_UP: begin
            if (r_cnt == r_period_act)
              w_dir_next = DIR_DOWN;
            else
              w_cnt_next = r_cnt + 1'b1;
          end
          DIR_DOWN: begin
            if (r_cnt == '0) begin
              w_dir_next = DIR_UP;
              w_boundary = 1'b1;
            end else begin
              w_cnt_next = r_cnt - 1'b1;
            end
          end
          default: w_dir_next = DIR_UP;
        endcase
      end else if (r_cnt == r_period_act) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
        w_dir_next = DIR_UP;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
`else
    if (w_tick) begin
      if (r_cnt == r_period_act) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
`endif
  end

  assign w_update = !rst_counter || w_boundary;
  assign w_apply  = w_update && (r_pend || duty_load);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc_cnt     <= '0;
      r_cnt         <= '0;
      r_period_done <= 1'b0;
    end else if (!rst_counter) begin
      r_psc_cnt     <= '0;
      r_cnt         <= '0;
      r_period_done <= 1'b0;
    end else begin
      if (en)
        r_psc_cnt <= w_tick ? '0 : r_psc_cnt + 1'b1;
      r_cnt         <= w_cnt_next;
      r_period_done <= w_boundary;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  // Direction register; the mode select is only re-sampled where the count restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir    <= DIR_UP;
      r_center <= 1'b0;
    end else if (!rst_counter) begin
      r_dir    <= DIR_UP;
      r_center <= center_mode;
    end else begin
      r_dir <= w_dir_next;
      if (w_boundary)
        r_center <= center_mode;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period_shd <= '0;
      r_period_act <= '0;
      r_pend       <= 1'b0;
    end else begin
      if (duty_load)
        r_period_shd <= period;
      if (w_apply)
        r_period_act <= duty_load ? period : r_period_shd;
      if (w_update)
        r_pend <= 1'b0;
      else if (duty_load)
        r_pend <= 1'b1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_compare_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (en),
      .i_clr   (!rst_counter),
      .i_load  (duty_load),
      .i_apply (w_apply),
      .i_duty  (duty[lane_lsb(i, CNT_W) +: CNT_W]),
      .i_cnt   (r_cnt),
      .o_pwm   (pwm[i])
    );
  end

  assign period_done = r_period_done;

endmodule
